pulse_generator: RTL
====================

# pulse_generator

Programmable square-wave source, the transmit-side counterpart of `frequency_counter`. It drives `FREQ_OUT` low for `LOW_CYCLES` clocks, then high for `HIGH_CYCLES` clocks, and repeats. New settings are double-buffered and applied only at a period boundary, so a `frequency_counter` watching the output never measures a torn period. It sits next to the counter in the fast-readout block and serves as the on-chip stimulus and loopback source.

## Interface
- `WIDTH`, 32: width of the cycle-count fields and the internal counter.
- `CLK` input 1: system clock. All logic runs on the rising edge.
- `RST_N` input 1: reset, asynchronous, active-high.
- `ENABLE` input 1: run request, level-sensitive.
- `LOAD` input 1: configuration valid strobe.
- `READY` output 1: configuration slot free. A transfer happens when `LOAD && READY`.
- `HIGH_CYCLES` input WIDTH: high-phase length in clocks. Sampled on transfer.
- `LOW_CYCLES` input WIDTH: low-phase length in clocks. Sampled on transfer.
- `FREQ_OUT` output 1: generated waveform, registered.
- `BUSY` output 1: high whenever the FSM is not in IDLE.
- `PERIOD_DONE` output 1: one-cycle pulse during the final high cycle of each period.
- `CFG_ERR` output 1: one-cycle pulse when a zero-length configuration is rejected.

## Operation
- Registers:
  - pending pair plus `pend_vld`.
  - active pair `act_hi` and `act_lo` (both reset to 0).
  - phase counter `cnt` (WIDTH bits).
- `READY = !pend_vld`.
- On a transfer with both fields nonzero: capture into pending and set `pend_vld`.
- On a transfer where either field is 0: leave pending untouched and pulse `CFG_ERR` on the next cycle.
- `LOAD` while `READY` = 0 is ignored, with no error.
- States are IDLE, LOW and HIGH.
  - IDLE: `FREQ_OUT` = 0.
    - If `pend_vld`, copy pending into active and clear `pend_vld`.
    - If `ENABLE` is high and active values are nonzero, go to LOW with `cnt` = 1.
  - LOW: `FREQ_OUT` = 0.
    - If `cnt == act_lo`, go to HIGH with `cnt` = 1.
    - Otherwise increment `cnt`.
  - HIGH: `FREQ_OUT` = 1.
    - If `cnt == act_hi`, it is the period boundary: assert `PERIOD_DONE`.
      - If `pend_vld`, apply pending to active.
      - If `ENABLE` is high, go to LOW with `cnt` = 1; otherwise go to IDLE.
    - Otherwise increment `cnt`.
- Deasserting `ENABLE` mid-period is graceful: the current period always completes before IDLE.
- Arithmetic: `cnt` never exceeds the active limit, so it cannot wrap. The maximum phase is 2^WIDTH−1 clocks.
- A transfer in the same cycle as a boundary lands in pending after that boundary and is applied at the next boundary.
- Reset mid-operation immediately forces all outputs to their reset values and discards both pending and active configuration.

## Timing
- Reset values: `FREQ_OUT` 0, `READY` 1, `BUSY` 0, `PERIOD_DONE` 0, `CFG_ERR` 0.
- Start-up latency from IDLE with a valid pending configuration:
  - Edge 1: the configuration is applied.
  - Edge 2: LOW is entered, if `ENABLE` is high.
- If the configuration is already active, LOW is entered on the first edge where `ENABLE` is sampled high.
- Steady state gives exactly `act_lo` clocks low, then `act_hi` clocks high. Period = `act_lo + act_hi`, with no gap cycles.
- `READY` rises in the cycle after pending is applied.
- `CFG_ERR` is asserted in the cycle after the offending transfer.

## Configuration
- `PULSE_GEN_BURST_EN` defined:
  - Adds input `BURST_COUNT[15:0]`, sampled with each accepted configuration.
  - Value 0 means continuous output.
  - Value N>0 means the generator emits exactly N periods, then goes to IDLE even if `ENABLE` is still high.
  - A new rising edge of `ENABLE` is required to emit another burst.
  - Adds output `BURST_DONE`, a one-cycle pulse coincident with the last `PERIOD_DONE`.
- Undefined: no burst port, output is continuous while `ENABLE` is high, and behaviour is as described above.

## Test plan
- Reset, load L=3 H=5, hold `ENABLE`:
  - `FREQ_OUT` gives 3 low, 5 high, repeating.
  - `PERIOD_DONE` occurs every 8 clocks.
  - A `frequency_counter` on the loopback reads TIME_LOW=3, TIME_HIGH=5, PERIOD=8.
- While running L=3 H=5, load L=10 H=2 mid-HIGH:
  - The current period stays 3/5.
  - The next period is 10/2.
  - `READY` is low until the boundary, then returns to 1.
- Load H=0 L=4:
  - `CFG_ERR` pulses once.
  - `READY` stays 1.
  - The active configuration is unchanged and the output is unaffected.
- L=1 H=1 (minimum):
  - `FREQ_OUT` toggles every clock.
  - `PERIOD_DONE` occurs every 2 clocks.
- Drop `ENABLE` in cycle 2 of a 4/6 LOW phase: the period completes (4 low, 6 high), then the block is in IDLE with `BUSY` 0.
- Assert `RST_N` during HIGH: outputs are at reset values immediately, and re-enabling without a new load stays in IDLE.
- With `PULSE_GEN_BURST_EN`, BURST_COUNT=3 and L=2 H=2: exactly 3 periods are emitted, `BURST_DONE` pulses once, and the output then stays low while `ENABLE` is held high.

Source files
------------

// File: rtl/pulse_generator.sv
// Square-wave source: LOW_CYCLES low then HIGH_CYCLES high, settings double-buffered to period boundaries.
// Optional PULSE_GEN_BURST_EN adds BURST_COUNT/BURST_DONE for finite bursts of periods.
module pulse_generator #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENABLE,
    input  logic             LOAD,
    output logic             READY,
    input  logic [WIDTH-1:0] HIGH_CYCLES,
    input  logic [WIDTH-1:0] LOW_CYCLES,
`ifdef PULSE_GEN_BURST_EN
    input  logic [15:0]      BURST_COUNT,
    output logic             BURST_DONE,
`endif
    output logic             FREQ_OUT,
    output logic             BUSY,
    output logic             PERIOD_DONE,
    output logic             CFG_ERR
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_cnt;
    logic             r_freq_out;
    logic [WIDTH-1:0] r_pend_hi, r_pend_lo;
    logic             r_pend_vld;
    logic [WIDTH-1:0] r_act_hi, r_act_lo;
    logic             r_cfg_err;

    logic w_xfer, w_cfg_ok, w_accept, w_lo_end, w_hi_end, w_apply, w_act_ok;
    logic w_start, w_burst_last;

    assign w_xfer   = LOAD && !r_pend_vld;
    assign w_cfg_ok = (HIGH_CYCLES != '0) && (LOW_CYCLES != '0);
    assign w_accept = w_xfer && w_cfg_ok;
    assign w_lo_end = (r_state == S_LOW)  && (r_cnt == r_act_lo);
    assign w_hi_end = (r_state == S_HIGH) && (r_cnt == r_act_hi);
    // Pending settings only move to active while idle or on the last high cycle.
    assign w_apply  = r_pend_vld && ((r_state == S_IDLE) || w_hi_end);
    assign w_act_ok = (r_act_hi != '0) && (r_act_lo != '0);

`ifdef PULSE_GEN_BURST_EN
    logic [15:0] r_pend_burst, r_act_burst, r_burst_cnt;
    logic        r_burst_hold;
    logic [15:0] w_burst_next;

    assign w_burst_next = r_burst_cnt + 16'd1;
    assign w_burst_last = (r_act_burst != 16'd0) && (w_burst_next == r_act_burst);
    // After a finished burst, ENABLE must drop before another start is allowed.
    assign w_start      = ENABLE && w_act_ok && !r_burst_hold;
    assign BURST_DONE   = w_hi_end && w_burst_last;

    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            r_pend_burst <= 16'd0;
            r_act_burst  <= 16'd0;
            r_burst_cnt  <= 16'd0;
            r_burst_hold <= 1'b0;
        end else begin
            if (w_accept)
                r_pend_burst <= BURST_COUNT;
            if (w_apply)
                r_act_burst <= r_pend_burst;
            if ((r_state == S_IDLE) || w_apply)
                r_burst_cnt <= 16'd0;
            else if (w_hi_end)
                r_burst_cnt <= w_burst_next;
            if (!ENABLE)
                r_burst_hold <= 1'b0;
            else if (BURST_DONE)
                r_burst_hold <= 1'b1;
        end
    end
`else
    assign w_burst_last = 1'b0;
    assign w_start      = ENABLE && w_act_ok;
`endif

    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            r_pend_hi  <= '0;
            r_pend_lo  <= '0;
            r_pend_vld <= 1'b0;
            r_act_hi   <= '0;
            r_act_lo   <= '0;
            r_cfg_err  <= 1'b0;
        end else begin
            // apply needs pend_vld=1 and accept needs pend_vld=0, so they never collide
            if (w_apply) begin
                r_act_hi   <= r_pend_hi;
                r_act_lo   <= r_pend_lo;
                r_pend_vld <= 1'b0;
            end else if (w_accept) begin
                r_pend_hi  <= HIGH_CYCLES;
                r_pend_lo  <= LOW_CYCLES;
                r_pend_vld <= 1'b1;
            end
            r_cfg_err <= w_xfer && !w_cfg_ok;
        end
    end

    always_ff @(posedge CLK or posedge RST_N) begin
        if (RST_N) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_freq_out <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_freq_out <= 1'b0;
                    if (w_start) begin
                        r_state <= S_LOW;
                        r_cnt   <= ONE;
                    end
                end
                S_LOW: begin
                    if (w_lo_end) begin
                        r_state    <= S_HIGH;
                        r_cnt      <= ONE;
                        r_freq_out <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
                S_HIGH: begin
                    if (w_hi_end) begin
                        r_freq_out <= 1'b0;
                        if (ENABLE && !w_burst_last) begin
                            r_state <= S_LOW;
                            r_cnt   <= ONE;
                        end else begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_cnt      <= '0;
                    r_freq_out <= 1'b0;
                end
            endcase
        end
    end

    assign READY       = !r_pend_vld;
    assign FREQ_OUT    = r_freq_out;
    assign BUSY        = (r_state != S_IDLE);
    assign PERIOD_DONE = w_hi_end;
    assign CFG_ERR     = r_cfg_err;

endmodule
